// File: rtl/can_timing_pkg.sv
// Shared constants for the CAN bit-timing slice: default config widths and segment codes.
package can_timing_pkg;
   localparam int BRP_W = 6;
   localparam int TS1_W = 4;
   localparam int TS2_W = 3;

   localparam logic [1:0] SEG_SYNC  = 2'd0;
   localparam logic [1:0] SEG_TSEG1 = 2'd1;
   localparam logic [1:0] SEG_TSEG2 = 2'd2;
endpackage

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: counts 0..brp and flags the first and last clk of every tq.
// clr restarts the quantum in the same clk (the clr cycle is tq clk 0).
module can_tq_prescaler #(
   parameter int BRP_W = can_timing_pkg::BRP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [BRP_W-1:0] brp,
   output logic             tq_tick,
   output logic             tq_first
);
   import can_timing_pkg::*;

   logic [BRP_W-1:0] cnt_q, cnt_d, cnt_c;

   always_comb begin
      cnt_c    = clr ? '0 : cnt_q;
      tq_tick  = (cnt_c == brp);
      tq_first = (cnt_c == '0);
      cnt_d    = tq_tick ? '0 : cnt_c + BRP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: SYNC/TSEG1/TSEG2 sequencing with hard sync and SJW-limited resync.
// Strobes are combinational from state; a bus edge reaches the FSM 2 clk after rx changes.
module can_bit_timing #(
   parameter int BRP_W = can_timing_pkg::BRP_W,
   parameter int TS1_W = can_timing_pkg::TS1_W,
   parameter int TS2_W = can_timing_pkg::TS2_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic [BRP_W-1:0] brp,
   input  logic [TS1_W-1:0] tseg1,
   input  logic [TS2_W-1:0] tseg2,
   input  logic [1:0]       sjw,
   input  logic             hard_sync_en,
   output logic             sample_point,
   output logic             rx_bit,
   output logic             bit_start,
   output logic [1:0]       seg
);
   import can_timing_pkg::*;

   localparam int CW = TS1_W + 1;

   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic             rx_bit_q, rx_bit_d, started_q, started_d, done_q, done_d;
   logic [1:0]       seg_q, seg_d;
   logic [CW-1:0]    cnt_q, cnt_d, ext_q, ext_d, shr_q, shr_d;
   logic [BRP_W-1:0] brp_q, brp_d, brp_c;
   logic [TS1_W-1:0] tseg1_q, tseg1_d, tseg1_c;
   logic [TS2_W-1:0] tseg2_q, tseg2_d, tseg2_c;
   logic [1:0]       sjw_q, sjw_d, sjw_c;

   logic          edge_det, hard_sync, soft_sync, tq_tick, tq_first, cfg_ld;
   logic [1:0]    seg_c;
   logic [CW-1:0] cnt_c, ext_c, shr_c, ext_n, shr_n;
   logic [CW-1:0] tseg1_x, tseg2_x, sjw_x, sjw_eff;
   logic          done_c, done_n;

   // The prescaler stays cleared until the grid starts, so the first bit opens on a fresh tq.
   can_tq_prescaler #(.BRP_W(BRP_W)) u_presc (
      .clk      (clk),
      .rst      (rst & started_q),
      .clr      (hard_sync),
      .brp      (brp_c),
      .tq_tick  (tq_tick),
      .tq_first (tq_first)
   );

   always_comb begin
      edge_det  = started_q & prev_q & ~sync2_q & rx_bit_q;
      hard_sync = edge_det & hard_sync_en;

      brp_c   = hard_sync ? brp   : brp_q;
      tseg1_c = hard_sync ? tseg1 : tseg1_q;
      tseg2_c = hard_sync ? tseg2 : tseg2_q;
      sjw_c   = hard_sync ? sjw   : sjw_q;
      tseg1_x = CW'(tseg1_c);
      tseg2_x = CW'(tseg2_c);
      sjw_x   = CW'(sjw_c);
      sjw_eff = (sjw_x < tseg2_x) ? sjw_x + CW'(1) : tseg2_x + CW'(1);

      // A hard sync makes this clk the first clk of a fresh SYNC.
      seg_c  = hard_sync ? SEG_SYNC : seg_q;
      cnt_c  = hard_sync ? '0 : cnt_q;
      ext_c  = hard_sync ? '0 : ext_q;
      shr_c  = hard_sync ? '0 : shr_q;
      done_c = hard_sync ? 1'b0 : done_q;

      ext_n     = ext_c;
      shr_n     = shr_c;
      done_n    = done_c;
      soft_sync = edge_det & ~hard_sync_en & ~done_c & (seg_c != SEG_SYNC);
      if (soft_sync) begin
         done_n = 1'b1;
         if (seg_c == SEG_TSEG1)
            ext_n = (cnt_c + CW'(1) < sjw_eff) ? cnt_c + CW'(1) : sjw_eff;
         else
            shr_n = (tseg2_x - cnt_c < sjw_eff) ? tseg2_x - cnt_c : sjw_eff;
      end

      seg_d  = seg_c;
      cnt_d  = cnt_c;
      ext_d  = ext_n;
      shr_d  = shr_n;
      done_d = done_n;
      cfg_ld = ~started_q | hard_sync;
      if (started_q && tq_tick) begin
         case (seg_c)
            SEG_SYNC: begin
               seg_d = SEG_TSEG1;
               cnt_d = '0;
            end
            SEG_TSEG1: begin
               if (cnt_c == tseg1_x + ext_n) begin
                  seg_d = SEG_TSEG2;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_c + CW'(1);
               end
            end
            default: begin
               if (cnt_c + shr_n >= tseg2_x) begin
                  seg_d  = SEG_SYNC;
                  cnt_d  = '0;
                  ext_d  = '0;
                  shr_d  = '0;
                  done_d = 1'b0;
                  cfg_ld = 1'b1;
               end else begin
                  cnt_d = cnt_c + CW'(1);
               end
            end
         endcase
      end

      brp_d   = cfg_ld ? brp   : brp_q;
      tseg1_d = cfg_ld ? tseg1 : tseg1_q;
      tseg2_d = cfg_ld ? tseg2 : tseg2_q;
      sjw_d   = cfg_ld ? sjw   : sjw_q;

      sample_point = rst & started_q & (seg_c == SEG_TSEG2) & (cnt_c == '0) & tq_first;
      bit_start    = rst & started_q & (seg_c == SEG_SYNC) & tq_first;
      rx_bit_d     = sample_point ? sync2_q : rx_bit_q;
      rx_bit       = rx_bit_d;
      seg          = seg_c;

      sync1_d   = rx;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      started_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         rx_bit_q  <= 1'b1;
         started_q <= 1'b0;
         done_q    <= 1'b0;
         seg_q     <= SEG_SYNC;
         cnt_q     <= '0;
         ext_q     <= '0;
         shr_q     <= '0;
         brp_q     <= '0;
         tseg1_q   <= '0;
         tseg2_q   <= '0;
         sjw_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         rx_bit_q  <= rx_bit_d;
         started_q <= started_d;
         done_q    <= done_d;
         seg_q     <= seg_d;
         cnt_q     <= cnt_d;
         ext_q     <= ext_d;
         shr_q     <= shr_d;
         brp_q     <= brp_d;
         tseg1_q   <= tseg1_d;
         tseg2_q   <= tseg2_d;
         sjw_q     <= sjw_d;
      end
   end
endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: nominal grid, hard sync, soft resync, double edge, mid-bit reset.
module tb_can_bit_timing;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic [5:0] brp = 6'd0;
   logic [3:0] tseg1 = 4'd5;
   logic [2:0] tseg2 = 3'd2;
   logic [1:0] sjw = 2'd0;
   logic       hard_sync_en = 1'b0;
   logic       sample_point, rx_bit, bit_start;
   logic [1:0] seg;

   int n_chk = 0;
   int n_pass = 0;
   int n;

   can_bit_timing dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .brp          (brp),
      .tseg1        (tseg1),
      .tseg2        (tseg2),
      .sjw          (sjw),
      .hard_sync_en (hard_sync_en),
      .sample_point (sample_point),
      .rx_bit       (rx_bit),
      .bit_start    (bit_start),
      .seg          (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Counts falling clock edges until the chosen strobe is seen; -1 if it never comes.
   task automatic wait_evt(input bit want_sp, output int cnt);
      bit hit;
      hit = 1'b0;
      cnt = 0;
      while (!hit && cnt < 100) begin
         @(negedge clk);
         cnt++;
         hit = want_sp ? sample_point : bit_start;
      end
      if (!hit) cnt = -1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_sample_point", int'(sample_point), 0);
      check("rst_bit_start", int'(bit_start), 0);
      check("rst_rx_bit", int'(rx_bit), 1);
      check("rst_seg", int'(seg), 0);
      rst = 1'b1;
      wait_evt(1'b0, n);
      check("first_bit_start", n, 1);
      check("seg_in_sync", int'(seg), 0);

      // Idle bus, 10 clk bits, sample 7 clk into each bit.
      for (int i = 0; i < 2; i++) begin
         wait_evt(1'b1, n);
         check("nom_bs_to_sp", n, 7);
         check("nom_rx_bit", int'(rx_bit), 1);
         check("nom_seg_tseg2", int'(seg), 2);
         wait_evt(1'b0, n);
         check("nom_sp_to_bs", n, 3);
      end

      // Hard sync on a fall during TSEG2.
      hard_sync_en = 1'b1;
      wait_evt(1'b0, n);
      repeat (6) @(negedge clk);
      rx = 1'b0;
      wait_evt(1'b0, n);
      check("hs_fall_to_bs", n, 2);
      wait_evt(1'b1, n);
      check("hs_bs_to_sp", n, 7);
      check("hs_rx_bit", int'(rx_bit), 0);
      rx = 1'b1;
      hard_sync_en = 1'b0;
      repeat (2) wait_evt(1'b0, n);

      // Soft resync in TSEG1 tq 2 with sjw=0: +1 tq.
      wait_evt(1'b0, n);
      @(negedge clk);
      rx = 1'b0;
      wait_evt(1'b0, n);
      check("ts1_resync_bit_len", n + 1, 11);
      rx = 1'b1;
      wait_evt(1'b0, n);
      check("ts1_next_bit_len", n, 10);

      // Soft resync in TSEG2 tq 0 with sjw=1: -2 tq.
      sjw = 2'd1;
      repeat (2) wait_evt(1'b0, n);
      repeat (5) @(negedge clk);
      rx = 1'b0;
      wait_evt(1'b0, n);
      check("ts2_resync_bit_len", n + 5, 8);
      rx = 1'b1;
      wait_evt(1'b0, n);
      check("ts2_next_bit_len", n, 10);

      // Two edges in one bit with sjw=3: tq1 edge gives +2, the tq5 edge is ignored.
      sjw = 2'd3;
      repeat (2) wait_evt(1'b0, n);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rx = 1'b0;
      wait_evt(1'b0, n);
      check("two_edge_bit_len", n + 4, 12);
      rx = 1'b1;
      repeat (2) wait_evt(1'b0, n);
      check("after_two_edge_len", n, 10);

      // Reset mid-TSEG1 with brp=3.
      brp = 6'd3;
      sjw = 2'd0;
      repeat (2) wait_evt(1'b0, n);
      repeat (6) @(negedge clk);
      check("brp3_seg_tseg1", int'(seg), 1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_sample_point", int'(sample_point), 0);
      check("mid_rst_bit_start", int'(bit_start), 0);
      check("mid_rst_rx_bit", int'(rx_bit), 1);
      check("mid_rst_seg", int'(seg), 0);
      rst = 1'b1;
      wait_evt(1'b0, n);
      check("rel_to_bs", n, 1);
      wait_evt(1'b1, n);
      check("rel_bs_to_sp", n, 28);
      wait_evt(1'b0, n);
      check("brp3_sp_to_bs", n, 12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
